// File: rtl/m_dispatch_ctrl_pkg.sv
// Shared types for the dispatch controller: instruction kinds, FSM states
// and default memory in-flight limit.
package m_dispatch_ctrl_pkg;

    typedef enum logic [2:0] {
        KIND_RRR,
        KIND_RRI,
        KIND_MEMORY,
        KIND_MODEL,
        KIND_CUSTOM,
        KIND_INVALID
    } e_kind;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DRAIN,
        TRAP
    } e_dispatch_state;

    localparam int DISPATCH_MEM_MAX_DEFAULT = 4;

endpackage

// File: rtl/m_dispatch_ctrl_decoder_kind.sv
// Instruction classifier: maps the major opcode nibble (bits 31:28)
// of an instruction onto an e_kind.
module m_decoder_kind
    import m_dispatch_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output e_kind      kind
);

    always_comb begin
        kind = KIND_INVALID;
        case (op)
            4'h0:    kind = KIND_RRR;
            4'h4:    kind = KIND_RRI;
            4'h1:    kind = KIND_MEMORY;
            4'h2:    kind = KIND_MODEL;
            4'hc:    kind = KIND_CUSTOM;
            default: kind = KIND_INVALID;
        endcase
    end

endmodule

// File: rtl/m_dispatch_ctrl.sv
// Issue-stage dispatcher: one-entry slot routed by kind to the functional units.
// Optional DISPATCH_CUSTOM_EN routes KIND_CUSTOM to the custom port; otherwise it traps.
module m_dispatch_ctrl
    import m_dispatch_ctrl_pkg::*;
#(
    parameter int MEM_MAX = DISPATCH_MEM_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    output logic [31:0] issue_instr,
    output e_kind       issue_kind,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic        mem_done,
    output logic        model_valid,
    input  logic        model_ready,
    output logic        custom_valid,
    input  logic        custom_ready,
    output logic        trap,
    input  logic        trap_ack
);

    localparam int CW = $clog2(MEM_MAX + 1);

    e_dispatch_state state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [31:0]     slot;
    e_kind           kind;
    logic            hold, is_alu, is_mem, is_model, is_custom, is_bad;
    logic            hs, accept, inc, dec;

    m_decoder_kind u_dec (
        .op   (slot[31:28]),
        .kind (kind)
    );

    assign issue_instr = slot;
    assign issue_kind  = kind;
    assign hold        = (state == HOLD);
    assign is_alu      = (kind == KIND_RRR) || (kind == KIND_RRI);
    assign is_mem      = (kind == KIND_MEMORY);
    assign is_model    = (kind == KIND_MODEL);

`ifdef DISPATCH_CUSTOM_EN
    assign is_custom = (kind == KIND_CUSTOM);
    assign is_bad    = (kind == KIND_INVALID);
`else
    logic unused_custom_ready;
    assign unused_custom_ready = custom_ready;
    assign is_custom = 1'b0;
    assign is_bad    = (kind == KIND_INVALID) || (kind == KIND_CUSTOM);
`endif

    // Valids come only from registered state/count, never from a ready input.
    assign alu_valid    = hold && is_alu;
    assign mem_valid    = hold && is_mem && (count != CW'(MEM_MAX));
    assign model_valid  = hold && is_model && (count == '0);
    assign custom_valid = hold && is_custom;
    assign trap         = (state == TRAP);

`ifdef DISPATCH_CUSTOM_EN
    assign hs = (alu_valid && alu_ready) || (mem_valid && mem_ready)
             || (model_valid && model_ready) || (custom_valid && custom_ready);
`else
    assign hs = (alu_valid && alu_ready) || (mem_valid && mem_ready)
             || (model_valid && model_ready);
`endif

    assign instr_ready = (state == IDLE) || hs;
    assign accept      = instr_valid && instr_ready;
    assign inc         = mem_valid && mem_ready;
    assign dec         = mem_done && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({inc, dec})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: begin
                if (accept)
                    state_nxt = HOLD;
                else if (hs)
                    state_nxt = IDLE;
                else if (is_bad)
                    state_nxt = TRAP;
                else if (is_model && count_nxt != '0)
                    state_nxt = DRAIN;
            end
            // Count cannot rise here, so the model op is released as soon as it drains.
            DRAIN: if (count_nxt == '0) state_nxt = HOLD;
            TRAP:  if (trap_ack) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) slot <= instruction;
        end
    end

endmodule
